// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, captures ROM words into a small circular queue and
// hands them to decode over valid/ready. Optional macro IFU_BOUND_CHECK_EN stops fetch past the ROM end.
module instr_fetch_unit #(
  parameter int          MEM_DEPTH = 256,
  parameter int          QDEPTH    = 2,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_err
);

  localparam logic [1:0]  LAST_PTR = 2'(QDEPTH - 1);
  localparam logic [2:0]  DEPTH_C  = 3'(QDEPTH);
  localparam logic [31:0] LAST_PC  = 32'(MEM_DEPTH - 1);
  localparam logic [31:0] DEPTH_PC = 32'(MEM_DEPTH);

  // Handshake: decode takes the head on a cycle where instr_valid && instr_ready are
  // both high; instr/instr_pc stay put while instr_valid is high and instr_ready is low.
  logic [31:0] q_instr_q [4];
  logic [31:0] q_instr_d [4];
  logic [31:0] q_pc_q    [4];
  logic [31:0] q_pc_d    [4];
  logic [1:0]  head_q, head_d, tail_q, tail_d;
  logic [2:0]  count_q, count_d;
  logic [31:0] pc_q, pc_d;
  logic        err_q, err_d;
  logic        pop, push, fetch_en;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    q_instr_d = q_instr_q;
    q_pc_d    = q_pc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    pc_d      = pc_q;
    err_d     = err_q;
`ifdef IFU_BOUND_CHECK_EN
    fetch_en  = !err_q;
`else
    fetch_en  = 1'b1;
`endif
    pop  = (count_q != 3'd0) && instr_ready;
    push = !stall && !redirect_valid && ((count_q < DEPTH_C) || pop) && fetch_en;

    if (redirect_valid) begin
      // Flush wins over everything; a same-cycle pop is simply lost with the flush.
      head_d  = 2'd0;
      tail_d  = 2'd0;
      count_d = 3'd0;
`ifdef IFU_BOUND_CHECK_EN
      pc_d  = redirect_pc;
      err_d = (redirect_pc >= DEPTH_PC);
`else
      pc_d  = redirect_pc % DEPTH_PC;
`endif
    end else begin
      if (push) begin
        q_instr_d[tail_q] = imem_data;
        q_pc_d[tail_q]    = pc_q;
        tail_d            = ptr_inc(tail_q);
`ifdef IFU_BOUND_CHECK_EN
        pc_d = pc_q + 32'd1;
        if (pc_q == LAST_PC) err_d = 1'b1;
`else
        pc_d = (pc_q == LAST_PC) ? 32'd0 : pc_q + 32'd1;
`endif
      end
      if (pop) head_d = ptr_inc(head_q);
      count_d = count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        q_instr_q[i] <= 32'd0;
        q_pc_q[i]    <= 32'd0;
      end
      head_q  <= 2'd0;
      tail_q  <= 2'd0;
      count_q <= 3'd0;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      q_instr_q <= q_instr_d;
      q_pc_q    <= q_pc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      pc_q      <= pc_d;
      err_q     <= err_d;
    end
  end

  assign imem_pc     = pc_q;
  assign instr_valid = (count_q != 3'd0);
  assign instr       = q_instr_q[head_q];
  assign instr_pc    = q_pc_q[head_q];
`ifdef IFU_BOUND_CHECK_EN
  assign fetch_err   = err_q;
`else
  assign fetch_err   = 1'b0;
`endif

endmodule
